// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, one write port, optional
// write-to-read bypass and a per-register busy scoreboard for hazard checks.

module regfile_sb_rdport #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic                       rst,
    input  logic [AW-1:0]              raddr,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [XLEN-1:0]            wdata,
    input  logic [NREG-1:0][XLEN-1:0]  regs,
    input  logic [NREG-1:0]            busy,
    output logic [XLEN-1:0]            rdata,
    output logic                       rbusy
);
    logic fwd;

    always_comb begin
        fwd   = (BYPASS != 0) && we && (waddr == raddr);
        rdata = '0;
        rbusy = 1'b0;
        // x0 never forwards: raddr != 0 together with fwd implies waddr != 0
        if (!rst && raddr != '0) begin
            rdata = fwd ? wdata : regs[raddr];
            rbusy = busy[raddr] && !fwd;
        end
    end
endmodule

module regfile_sb #(
    parameter int              XLEN    = 32,
    parameter int              NREG    = 32,
    parameter int              AW      = $clog2(NREG),
    parameter int              NRD     = 2,
    parameter int              SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = 32'h0003_FFFC,
    parameter int              BYPASS  = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                issue,
    input  logic [AW-1:0]       issue_rd,
    output logic [NREG-1:0]     busy_vec
);
    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we && waddr != '0) begin
            regs_d[waddr] = wdata;
            busy_d[waddr] = 1'b0;
        end
        // set after clear: a new producer issued in the writeback cycle wins
        if (issue && issue_rd != '0)
            busy_d[issue_rd] = 1'b1;
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NREG; r++)
                regs_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_sb_rdport #(
            .XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS)
        ) u_rd (
            .rst  (RST),
            .raddr(raddr[i*AW +: AW]),
            .we   (we),
            .waddr(waddr),
            .wdata(wdata),
            .regs (regs_q),
            .busy (busy_q),
            .rdata(rdata[i*XLEN +: XLEN]),
            .rbusy(rbusy[i])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two instances (bypass on/off) share stimulus and are
// checked against an array-based reference model of the register file.

module tb_regfile_sb;
    localparam logic [31:0] SP_INIT = 32'h0003_FFFC;

    logic        CLK = 1'b0;
    logic        RST, we, issue;
    logic [4:0]  waddr, issue_rd;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  rbusy_b, rbusy_n;
    logic [31:0] bv_b, bv_n;

    always #5 CLK = ~CLK;

    regfile_sb #(.BYPASS(1)) dut (
        .CLK(CLK), .RST(RST), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .issue(issue), .issue_rd(issue_rd), .busy_vec(bv_b));

    regfile_sb #(.BYPASS(0)) dut_nb (
        .CLK(CLK), .RST(RST), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .issue(issue), .issue_rd(issue_rd), .busy_vec(bv_n));

    typedef struct {
        int          id;
        logic [63:0] rd_b, rd_n;
        logic [1:0]  rb_b, rb_n;
        logic [31:0] bv;
        bit          chk_bv;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0, checks = 0, step_id = 0;
    logic [31:0] mdl [32];
    bit          mbusy [32];
    bit          mvalid = 0;

    task automatic chk(input string name, input int id, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, got, exp);
        end
    endtask

    // Expected read of one port straight from the architectural rules.
    function automatic void exp_rd(input bit byp, input bit r, input bit w, input int wa,
                                   input logic [31:0] wd, input int a,
                                   output logic [31:0] d, output logic b);
        bit fwd;
        d = 0; b = 0;
        if (r || a == 0) return;
        fwd = byp && w && wa == a;
        d = fwd ? wd : mdl[a];
        b = mbusy[a] && !fwd;
    endfunction

    task automatic step(input bit r, input bit w, input int wa, input logic [31:0] wd,
                        input bit is, input int ird, input int ra0, input int ra1);
        exp_t e;
        logic [31:0] d0, d1;
        logic b0, b1;
        RST = r; we = w; waddr = wa[4:0]; wdata = wd;
        issue = is; issue_rd = ird[4:0];
        raddr = {ra1[4:0], ra0[4:0]};
        e.id = step_id++;
        exp_rd(1'b1, r, w, wa, wd, ra0, d0, b0);
        exp_rd(1'b1, r, w, wa, wd, ra1, d1, b1);
        e.rd_b = {d1, d0}; e.rb_b = {b1, b0};
        exp_rd(1'b0, r, w, wa, wd, ra0, d0, b0);
        exp_rd(1'b0, r, w, wa, wd, ra1, d1, b1);
        e.rd_n = {d1, d0}; e.rb_n = {b1, b0};
        e.chk_bv = mvalid;
        e.bv = '0;
        for (int i = 0; i < 32; i++) e.bv[i] = mbusy[i];
        sb.push_back(e);
        @(posedge CLK);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                mdl[i] = (i == 2) ? SP_INIT : 32'h0;
                mbusy[i] = 0;
            end
            mvalid = 1;
        end else begin
            if (w && wa != 0) begin mdl[wa] = wd; mbusy[wa] = 0; end
            if (is && ird != 0) mbusy[ird] = 1;
        end
        #1;
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rdata_bypass", e.id, rdata_b, e.rd_b);
            chk("rbusy_bypass", e.id, {62'h0, rbusy_b}, {62'h0, e.rb_b});
            chk("rdata_nobypass", e.id, rdata_n, e.rd_n);
            chk("rbusy_nobypass", e.id, {62'h0, rbusy_n}, {62'h0, e.rb_n});
            if (e.chk_bv) begin
                chk("busy_vec_bypass", e.id, {32'h0, bv_b}, {32'h0, e.bv});
                chk("busy_vec_nobypass", e.id, {32'h0, bv_n}, {32'h0, e.bv});
            end
        end
    end

    initial begin
        RST = 1; we = 0; issue = 0; waddr = 0; issue_rd = 0; wdata = 0; raddr = 0;
        @(posedge CLK); #1;
        // reset with write/issue that must be ignored
        step(1, 1, 5, 32'hDEAD, 1, 5, 2, 5);
        step(0, 0, 0, 0, 0, 0, 2, 5);
        // x0 hard-wired
        step(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // write/read with same-cycle bypass
        step(0, 1, 7, 32'h1234_5678, 0, 0, 7, 7);
        step(0, 0, 0, 0, 0, 0, 7, 0);
        // scoreboard lifecycle on x9
        step(0, 0, 0, 0, 1, 9, 0, 9);
        step(0, 0, 0, 0, 0, 0, 0, 9);
        step(0, 0, 0, 0, 0, 0, 0, 9);
        step(0, 1, 9, 32'hA5, 0, 0, 0, 9);
        step(0, 0, 0, 0, 0, 0, 0, 9);
        // simultaneous set and clear on x4
        step(0, 0, 0, 0, 1, 4, 4, 4);
        step(0, 1, 4, 32'hCAFE_F00D, 1, 4, 4, 4);
        step(0, 0, 0, 0, 0, 0, 4, 4);
        // reset mid-flight
        step(0, 1, 3, 32'h55, 0, 0, 3, 3);
        step(0, 0, 0, 0, 1, 3, 3, 2);
        step(0, 0, 0, 0, 1, 6, 6, 3);
        step(0, 0, 0, 0, 1, 11, 11, 3);
        step(1, 1, 6, 32'h99, 1, 12, 3, 2);
        step(0, 0, 0, 0, 0, 0, 3, 2);
        step(0, 1, 3, 32'h77, 1, 6, 3, 6);
        step(0, 0, 0, 0, 0, 0, 3, 6);
        // random traffic, addresses biased to a small window for collisions
        for (int n = 0; n < 400; n++) begin
            int wa, ird, a0, a1;
            wa  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            ird = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            a0  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            a1  = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 7);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) != 0, wa, $urandom,
                 $urandom_range(0, 1) != 0, ird, a0, a1);
        end
        @(negedge CLK); #1;
        chk("scoreboard_drained", step_id, 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
